reg_access_arbiter: RTL

REG_ACCESS_ARBITER -- requirements
Module: reg_access_arbiter

---
 rtl/reg_access_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter: three requesters share one 4-entry register bank command port.
// Optional macro REG_ARB_LOCK_EN adds per-requester Lock input for exclusive ownership.
module reg_access_arbiter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  req_i,
    input  logic [5:0]  req_sel_i,
    input  logic [5:0]  req_fun_sel_i,
    input  logic [47:0] req_data_i,
`ifdef REG_ARB_LOCK_EN
    input  logic [2:0]  lock_i,
`endif
    output logic [2:0]  gnt_o,
    output logic [3:0]  reg_e_o,
    output logic [1:0]  reg_fun_sel_o,
    output logic [15:0] reg_i_o,
    output logic        busy_o,
    output logic        state_o
);

    // Handshake: a requester holds req_i[i] and its fields stable until it
    // samples gnt_o[i] high; req_i[i] still high after gnt_o[i] drops is a new request.
    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [2:0]  gnt_q, gnt_d;
    logic [3:0]  reg_e_q, reg_e_d;
    logic [1:0]  fun_q, fun_d;
    logic [15:0] data_q, data_d;
    logic [1:0]  last_q, last_d;

    logic [2:0]  elig;
    logic [1:0]  c0, c1, c2;
    logic [1:0]  win;
    logic        has_win;
    logic [1:0]  sel_w;
    logic [1:0]  fun_w;
    logic [15:0] data_w;

`ifdef REG_ARB_LOCK_EN
    logic        owner_vld_q, owner_vld_d;
    logic [1:0]  owner_q, owner_d;
    logic        owner_rel_idle;
`endif

    always_comb begin
        elig = req_i & ~gnt_q;
`ifdef REG_ARB_LOCK_EN
        // Owner dropping its request outside a grant cycle frees the bus at this edge.
        owner_rel_idle = owner_vld_q && !req_i[owner_q] && !gnt_q[owner_q];
        if (owner_vld_q && !owner_rel_idle) begin
            elig = elig & (3'b001 << owner_q);
        end
`endif
        case (last_q)
            2'd0:    begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
            2'd1:    begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
            default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
        endcase
        has_win = |elig;
        if (elig[c0])      win = c0;
        else if (elig[c1]) win = c1;
        else               win = c2;
    end

    always_comb begin
        case (win)
            2'd0:    begin sel_w = req_sel_i[1:0]; fun_w = req_fun_sel_i[1:0]; data_w = req_data_i[15:0];  end
            2'd1:    begin sel_w = req_sel_i[3:2]; fun_w = req_fun_sel_i[3:2]; data_w = req_data_i[31:16]; end
            default: begin sel_w = req_sel_i[5:4]; fun_w = req_fun_sel_i[5:4]; data_w = req_data_i[47:32]; end
        endcase
    end

    always_comb begin
        state_d = IDLE;
        gnt_d   = 3'b000;
        reg_e_d = 4'b0000;
        fun_d   = fun_q;
        data_d  = data_q;
        last_d  = last_q;
`ifdef REG_ARB_LOCK_EN
        owner_vld_d = owner_vld_q && !owner_rel_idle;
        owner_d     = owner_q;
`endif
        if (has_win) begin
            state_d = ISSUE;
            gnt_d   = 3'b001 << win;
            reg_e_d = 4'b0001 << sel_w;
            fun_d   = fun_w;
            data_d  = data_w;
            last_d  = win;
`ifdef REG_ARB_LOCK_EN
            if (lock_i[win]) begin
                owner_vld_d = 1'b1;
                owner_d     = win;
            end else if (owner_vld_q && owner_q == win) begin
                owner_vld_d = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gnt_q   <= 3'b000;
            reg_e_q <= 4'b0000;
            fun_q   <= 2'b00;
            data_q  <= 16'h0000;
            last_q  <= 2'd2;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            reg_e_q <= reg_e_d;
            fun_q   <= fun_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

`ifdef REG_ARB_LOCK_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner_vld_q <= 1'b0;
            owner_q     <= 2'd0;
        end else begin
            owner_vld_q <= owner_vld_d;
            owner_q     <= owner_d;
        end
    end
`endif

    assign gnt_o         = gnt_q;
    assign reg_e_o       = reg_e_q;
    assign reg_fun_sel_o = fun_q;
    assign reg_i_o       = data_q;
    assign busy_o        = |reg_e_q;
    assign state_o       = state_q;

endmodule
